// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: round-robin grant,
// fixed four-phase access sequence, range checking and registered handshakes.

`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

module data_mem_arbiter #(
    parameter int DW        = `LEGV8_INTEGER_SZ,
    parameter int MEM_WORDS = 257
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          stall0,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [DW-1:0] ADDR_LIMIT = DW'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic addr_in_range(input logic [DW-1:0] a);
        return (a < ADDR_LIMIT);
    endfunction

    state_t        state_r;
    logic          last_grant_r;
    logic          gnt1_r;
    logic          we_r;
    logic          ok_r;
    logic [DW-1:0] rdata_r;
    logic          ack0_r;
    logic          ack1_r;
    logic          err0_r;
    logic          err1_r;
    logic [DW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          mem_read_r;
    logic          mem_write_r;

    logic          any_req_s;
    logic          pick1_s;
    logic          sel_we_s;
    logic [DW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          sel_ok_s;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        any_req_s   = req0 | req1;
        pick1_s     = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (req1 && (!req0 || !last_grant_r)) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
        if (pick1_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        sel_ok_s = addr_in_range(sel_addr_s);
    end

    // Access sequencer; every memory-side and handshake output is a register
    // loaded one state ahead so it is valid for the whole state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            gnt1_r       <= 1'b0;
            we_r         <= 1'b0;
            ok_r         <= 1'b0;
            rdata_r      <= '0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack0_r      <= 1'b0;
                    ack1_r      <= 1'b0;
                    err0_r      <= 1'b0;
                    err1_r      <= 1'b0;
                    mem_write_r <= 1'b0;
                    if (any_req_s) begin
                        state_r      <= SETUP;
                        last_grant_r <= pick1_s;
                        gnt1_r       <= pick1_s;
                        we_r         <= sel_we_s;
                        ok_r         <= sel_ok_s;
                        mem_addr_r   <= sel_addr_s;
                        mem_wdata_r  <= sel_wdata_s;
                        mem_read_r   <= ~sel_we_s & sel_ok_s;
                    end else begin
                        state_r     <= IDLE;
                        mem_addr_r  <= '0;
                        mem_wdata_r <= '0;
                        mem_read_r  <= 1'b0;
                    end
                end
                SETUP: begin
                    state_r     <= ACCESS;
                    mem_read_r  <= ~we_r & ok_r;
                    mem_write_r <= we_r & ok_r;
                end
                ACCESS: begin
                    state_r     <= DONE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    ack0_r      <= ~gnt1_r;
                    ack1_r      <= gnt1_r;
                    err0_r      <= ~gnt1_r & ~ok_r;
                    err1_r      <= gnt1_r & ~ok_r;
                    // Out-of-range reads return zero rather than stale data.
                    if (!we_r) begin
                        rdata_r <= ok_r ? mem_rdata : '0;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    ack0_r      <= 1'b0;
                    ack1_r      <= 1'b0;
                    err0_r      <= 1'b0;
                    err1_r      <= 1'b0;
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    ack0_r      <= 1'b0;
                    ack1_r      <= 1'b0;
                    err0_r      <= 1'b0;
                    err1_r      <= 1'b0;
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign err0      = err0_r;
    assign err1      = err1_r;
    assign rdata     = rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    // The pipeline must freeze the same cycle its request is still outstanding.
    assign stall0    = req0 & ~ack0_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed timing scenarios plus two randomized
// requesters, checked by a scoreboard fed at issue time and drained by a monitor.

module tb_data_mem_arbiter;

    localparam int MW = 257;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, stall0;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .stall0(stall0),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [63:0] rdata;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] ref_mem [0:MW-1];
    logic [63:0] mem [0:MW-1];
    int          wr_count [0:MW-1];
    logic        mem_init;
    int          rd_hi = 0;
    int          wr_hi = 0;
    logic [63:0] wr_addr_seen = 64'd0;
    logic [63:0] wr_data_seen = 64'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input int i);
        return (i == 2) ? 64'd5 : {32'hA5A5_0000, i};
    endfunction

    // Memory model: combinational read, write on the rising edge of the strobe.
    assign mem_rdata = (mem_read && mem_addr < 64'd257) ? mem[mem_addr[8:0]] : 64'd0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MW; i++) begin
                mem[i]      <= init_val(i);
                wr_count[i] <= 0;
            end
        end else if (mem_write && mem_addr < 64'd257) begin
            mem[mem_addr[8:0]]      <= mem_wdata;
            wr_count[mem_addr[8:0]] <= wr_count[mem_addr[8:0]] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks per-cycle invariants.
    always @(negedge clk) begin
        exp_t e;
        if (mem_read) rd_hi++;
        if (mem_write) begin
            wr_hi++;
            wr_addr_seen = mem_addr;
            wr_data_seen = mem_wdata;
        end
        check("stall0", 64'(stall0), 64'(req0 & ~ack0));
        check("ack_both", 64'(ack0 & ack1), 64'd0);
        check("rd_wr_both", 64'(mem_read & mem_write), 64'd0);
        if (ack0) begin
            if (q0.size() == 0) check("ack0_unexpected", 64'd1, 64'd0);
            else begin
                e = q0.pop_front();
                check("err0", 64'(err0), 64'(e.err));
                if (e.chk) check("rdata_p0", rdata, e.rdata);
            end
        end else check("err0_without_ack", 64'(err0), 64'd0);
        if (ack1) begin
            if (q1.size() == 0) check("ack1_unexpected", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                check("err1", 64'(err1), 64'(e.err));
                if (e.chk) check("rdata_p1", rdata, e.rdata);
            end
        end else check("err1_without_ack", 64'(err1), 64'd0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    // One access from port p: predicts the response, drives it, waits for ack.
    task automatic access(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, input logic chk_rd, input logic [63:0] rd_exp,
                          input bit scramble, output int lat, output int stall_cnt);
        exp_t e;
        logic got;
        e.err = (addr >= 64'd257);
        e.chk = !we || chk_rd;
        if (we) e.rdata = rd_exp;
        else e.rdata = e.err ? 64'd0 : ref_mem[addr[8:0]];
        if (we && !e.err) ref_mem[addr[8:0]] = wd;
        @(posedge clk); #1;
        if (p == 0) begin
            q0.push_back(e); req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
        end else begin
            q1.push_back(e); req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
        end
        lat = 0; stall_cnt = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            got = (p == 0) ? ack0 : ack1;
            if (!got && p == 0 && stall0) stall_cnt++;
            if (scramble && lat == 1) begin
                if (p == 0) begin
                    we0 = 1'($urandom_range(0, 1)); addr0 = 64'($urandom_range(0, 256)); wdata0 = {$urandom, $urandom};
                end else begin
                    we1 = 1'($urandom_range(0, 1)); addr1 = 64'($urandom_range(0, 256)); wdata1 = {$urandom, $urandom};
                end
            end
        end
        if (!got) check((p == 0) ? "ack0_timeout" : "ack1_timeout", 64'd0, 64'd1);
        if (p == 0) begin
            req0 = 1'b0; we0 = 1'b0; addr0 = 64'd0; wdata0 = 64'd0;
        end else begin
            req1 = 1'b0; we1 = 1'b0; addr1 = 64'd0; wdata1 = 64'd0;
        end
    endtask

    task automatic rand_port(input int p, input int n);
        int          lat, sc, r;
        logic        we;
        logic [63:0] a, wd;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            we = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            r  = int'($urandom_range(0, 11));
            if (r == 0)      a = 64'd257 + 64'($urandom_range(0, 2000));
            else if (r == 1) a = {1'b1, 31'($urandom), $urandom};
            else if (r == 2) a = (p == 0) ? 64'd256 : 64'd255;
            else             a = (p == 0) ? 64'(2 * $urandom_range(0, 128)) : 64'(2 * $urandom_range(0, 127) + 1);
            access(p, we, a, wd, 1'b0, 64'd0, 1'b0, lat, sc);
            check((p == 0) ? "latency_p0" : "latency_p1", 64'(lat >= 3 && lat <= 7), 64'd1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, 64'({ack0, ack1, err0, err1}), 64'd0);
        check({tag, "_mem_rw"}, 64'({mem_read, mem_write}), 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_rdata"}, rdata, 64'd0);
    endtask

    int lat0, lat1, sc0, sc1, rd_s, wr_s, wc_s, bad;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 64'd0; addr1 = 64'd0; wdata0 = 64'd0; wdata1 = 64'd0;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        // First tie after reset goes to port 0, port 1 follows four cycles later.
        fork
            access(0, 1'b0, 64'd2, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);
            access(1, 1'b0, 64'd3, 64'd0, 1'b0, 64'd0, 1'b0, lat1, sc1);
        join
        check("tie1_lat_p0", 64'(lat0), 64'd3);
        check("tie1_lat_p1", 64'(lat1), 64'd7);

        rd_s = rd_hi; wr_s = wr_hi;
        access(0, 1'b0, 64'd2, 64'd0, 1'b0, 64'd0, 1'b1, lat0, sc0);
        check("read_lat", 64'(lat0), 64'd3);
        check("read_mem_read_cycles", 64'(rd_hi - rd_s), 64'd2);
        check("read_mem_write_cycles", 64'(wr_hi - wr_s), 64'd0);
        check("read_stall_cycles", 64'(sc0), 64'd2);

        rd_s = rd_hi; wr_s = wr_hi;
        access(1, 1'b1, 64'd4, 64'h0000_0000_0000_00AB, 1'b1, 64'd5, 1'b1, lat1, sc1);
        check("write_lat", 64'(lat1), 64'd3);
        check("write_mem_write_cycles", 64'(wr_hi - wr_s), 64'd1);
        check("write_mem_read_cycles", 64'(rd_hi - rd_s), 64'd0);
        check("write_strobe_addr", wr_addr_seen, 64'd4);
        check("write_strobe_data", wr_data_seen, 64'h0000_0000_0000_00AB);
        access(0, 1'b0, 64'd4, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);

        // Port 0 was served last, so this tie goes to port 1.
        fork
            access(0, 1'b0, 64'd6, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);
            access(1, 1'b0, 64'd5, 64'd0, 1'b0, 64'd0, 1'b0, lat1, sc1);
        join
        check("tie2_lat_p1", 64'(lat1), 64'd3);
        check("tie2_lat_p0", 64'(lat0), 64'd7);

        rd_s = rd_hi; wr_s = wr_hi;
        access(0, 1'b0, 64'd300, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);
        access(1, 1'b1, 64'd257, 64'h1234, 1'b1, 64'd0, 1'b0, lat1, sc1);
        check("oor_mem_read_cycles", 64'(rd_hi - rd_s), 64'd0);
        check("oor_mem_write_cycles", 64'(wr_hi - wr_s), 64'd0);
        access(0, 1'b0, 64'd256, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);

        // Port 0 arrives while port 1 is already in SETUP.
        fork
            access(1, 1'b0, 64'd9, 64'd0, 1'b0, 64'd0, 1'b0, lat1, sc1);
            begin
                @(posedge clk);
                access(0, 1'b0, 64'd8, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);
            end
        join
        check("stall_lat_p1", 64'(lat1), 64'd3);
        check("stall_lat_p0", 64'(lat0), 64'd6);
        check("stall_cycles", 64'(sc0), 64'd5);

        // Reset while the write strobe is up: no ack, at most one memory write.
        @(posedge clk); #1;
        wc_s = wr_count[10];
        req1 = 1'b1; we1 = 1'b1; addr1 = 64'd10; wdata1 = 64'h77;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_mid_strobe_high", 64'(mem_write), 64'd1);
        check("rst_mid_strobe_addr", mem_addr, 64'd10);
        rst = 1'b1; req1 = 1'b0; we1 = 1'b0; addr1 = 64'd0; wdata1 = 64'd0;
        @(posedge clk); #1;
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        check("rst_mid_write_once", 64'(wr_count[10] - wc_s <= 1), 64'd1);
        if (wr_count[10] != wc_s) ref_mem[10] = 64'h77;
        access(0, 1'b0, 64'd2, 64'd0, 1'b0, 64'd0, 1'b0, lat0, sc0);
        check("post_rst_lat", 64'(lat0), 64'd3);

        fork
            rand_port(0, 80);
            rand_port(1, 80);
        join

        @(negedge clk); #1;
        bad = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_words_differing", 64'(bad), 64'd0);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default `LEGV8_INTEGER_SZ (64), meaning data/address width.
REQ-002 The block SHALL have parameter MEM_WORDS, default 257, meaning number of valid word addresses (0..MEM_WORDS-1).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0, req1  input  1 each  access request, port 0 = pipeline memory stage, port 1 = loader/debug.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0, addr1  input  DW each  word address; valid while reqN high.
REQ-008 wdata0, wdata1  input  DW each  write data; valid while reqN high.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse for that port.
REQ-010 err0, err1  output  1 each  one-cycle pulse coincident with ackN when the address was out of range.
REQ-011 rdata  output  DW  read result; valid in the ack cycle of a read.
REQ-012 stall0  output  1  combinational req0 && !ack0, drives pipeline stall.
REQ-013 mem_addr, mem_wdata  output  DW each  memory address and write data.
REQ-014 mem_read, mem_write  output  1 each  memory read enable; memory write strobe (memory writes on its rising edge).
REQ-015 mem_rdata  input  DW  memory read data (combinational from mem_addr when mem_read).

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; IDLE->SETUP when any req high; SETUP->ACCESS; ACCESS->DONE; DONE->IDLE unconditionally.
REQ-017 Arbitration SHALL occur only in IDLE: single requester wins; both high -> port not equal to last_grant wins (round-robin).
REQ-018 last_grant SHALL update on the IDLE->SETUP transition to the winning port.
REQ-019 On grant, the winning port's we/addr/wdata SHALL be latched; inputs changing afterwards SHALL not affect the access.
REQ-020 mem_addr/mem_wdata SHALL be driven from latched values in SETUP, ACCESS and DONE; 0 in IDLE.
REQ-021 Write: mem_write SHALL be high only during ACCESS (one cycle), giving one cycle of address/data setup before the strobe edge.
REQ-022 Read: mem_read SHALL be high in SETUP and ACCESS; mem_rdata SHALL be captured into rdata at the end of ACCESS.
REQ-023 Out-of-range address (latched addr >= MEM_WORDS): mem_read and mem_write SHALL stay 0; rdata SHALL be 0; errN SHALL pulse with ackN.
REQ-024 ackN SHALL be high exactly in the DONE cycle for the granted port only; latency from req sampled in IDLE (cycle N) to ack is cycle N+3.
REQ-025 rdata SHALL hold its value until the next read capture; a write leaves rdata unchanged.
REQ-026 Requesters SHALL deassert reqN in the cycle after ackN; a req still high in IDLE after DONE is treated as a new request.
REQ-027 The losing requester SHALL remain pending (no ack) and is served in the next arbitration, yielding back-to-back service with one IDLE cycle between.
REQ-028 Requests arriving during SETUP/ACCESS/DONE SHALL not be sampled until IDLE.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, last_grant=1 (so port 0 wins the first tie), rdata=0, latched registers=0.
REQ-030 During and after reset all of ack0/1, err0/1, mem_read, mem_write SHALL be 0; mem_addr/mem_wdata SHALL be 0.
REQ-031 Reset mid-access SHALL abort without any ack; if asserted in ACCESS of a write, mem_write SHALL fall to 0 at that edge.

Verification
REQ-032 Single read: req0=1, we0=0, addr0=2 with memory[2]=5 -> mem_read high 2 cycles, ack0 at N+3, rdata=5, err0=0.
REQ-033 Single write: req1=1, we1=1, addr1=4, wdata1=0xAB -> mem_write high exactly 1 cycle (ACCESS) with mem_addr=4; subsequent read of 4 returns 0xAB.
REQ-034 Contention: req0 and req1 high together after reset -> port 0 acked at N+3, port 1 acked at N+7; repeat tie -> port 1 first (round-robin).
REQ-035 Out of range: req0 read, addr0=300 -> mem_read/mem_write never high, ack0 and err0 pulse together, rdata=0.
REQ-036 Reset mid-write: assert rst in ACCESS -> no ack, FSM in IDLE next cycle, target memory word unchanged or written once, never twice.
REQ-037 stall0: req0 held during a port-1 access -> stall0=1 every cycle until ack0 cycle, where stall0=0.
